// File: rtl/sdram_dq_ctrl.sv
// sdram_dq_ctrl: SDRAM data-path sequencer. It drives write bursts onto the
// shared DQ bus and captures read bursts after the CAS latency. One burst runs
// at a time, and any start that arrives while a burst is running is rejected.
module sdram_dq_ctrl #(
  parameter int DW = 16,
  parameter int BL = 4,
  parameter int CL = 3,
  localparam int MW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_start,
  input  logic [DW-1:0] i_wr_data,
  input  logic [MW-1:0] i_wr_mask,
  output logic          o_wr_req,
  input  logic          i_rd_start,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_valid,
  output logic          o_rd_last,
  output logic          o_busy,
  output logic          o_err,
  output logic [MW-1:0] o_sdram_dqm,
  inout  logic [DW-1:0] io_sdram_dq
);

  // Burst counter width; when BL=1 the counter degenerates to a single bit.
  localparam int CW = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BL - 1);
  localparam logic [CW-1:0] PEN_CNT  = CW'((BL > 1) ? (BL - 2) : 0);
  localparam logic [1:0]    LAT_LAST = 2'(CL - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_READ    = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_lat;
  logic            r_busy;
  logic            r_err;
  logic            r_oe;
  logic [DW-1:0]   r_dq_out;
  logic [MW-1:0]   r_dqm;
  logic [DW-1:0]   r_rd_data;
  logic            r_rd_valid;
  logic            r_rd_last;

  logic            w_idle;
  logic            w_wr_go;
  logic            w_rd_go;
  logic            w_cnt_last;
  logic            w_lat_last;
  logic            w_wr_req;
  logic            w_sample;
  logic            w_sample_last;
  logic            w_err;

  // Decode start acceptance, word requests, read sampling points and rejects.
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_wr_go    = w_idle && i_wr_start;
    w_rd_go    = w_idle && i_rd_start && !i_wr_start;
    w_cnt_last = (r_cnt == LAST_CNT);
    w_lat_last = (r_lat == LAT_LAST);
    // A word is consumed in the start cycle and in every WRITE cycle but the last.
    w_wr_req   = w_wr_go || ((r_state == S_WRITE) && !w_cnt_last);
    // The bus is sampled in the final latency cycle and in every READ cycle but the last.
    w_sample   = ((r_state == S_RD_WAIT) && w_lat_last) ||
                 ((r_state == S_READ) && !w_cnt_last);
    if (BL == 1) begin
      w_sample_last = (r_state == S_RD_WAIT) && w_lat_last;
    end else begin
      w_sample_last = (r_state == S_READ) && (r_cnt == PEN_CNT);
    end
    // A start while busy, or two starts together, is flagged as rejected.
    w_err = (!w_idle && (i_wr_start || i_rd_start)) ||
            (w_idle && i_wr_start && i_rd_start);
  end

  // Burst state machine with its burst counter, latency counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lat   <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_go) begin
            r_state <= S_WRITE;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (w_rd_go) begin
            r_state <= S_RD_WAIT;
            r_lat   <= 2'd0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_WRITE: begin
          if (w_cnt_last) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RD_WAIT: begin
          if (w_lat_last) begin
            r_state <= S_READ;
            r_cnt   <= '0;
            r_lat   <= 2'd0;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_READ: begin
          if (w_cnt_last) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_lat   <= 2'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Register each requested write word and its mask, and drive them one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oe     <= 1'b0;
      r_dq_out <= '0;
      r_dqm    <= '0;
    end else begin
      r_oe <= w_wr_req;
      if (w_wr_req) begin
        r_dq_out <= i_wr_data;
        r_dqm    <= i_wr_mask;
      end else begin
        r_dqm    <= '0;
      end
    end
  end

  // Capture read words from the bus; rd_data holds its value between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_sample;
      r_rd_last  <= w_sample_last;
      if (w_sample) begin
        r_rd_data <= io_sdram_dq;
      end
    end
  end

  // A start that is rejected produces a one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
    end
  end

  assign io_sdram_dq = r_oe ? r_dq_out : {DW{1'bz}};
  assign o_wr_req    = w_wr_req;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_last   = r_rd_last;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_sdram_dqm = r_dqm;

endmodule

// File: tb/tb_sdram_dq_ctrl.sv
// Directed testbench for sdram_dq_ctrl: the default configuration plus two
// sweep configurations (DW=8/BL=1/CL=2 and DW=64/BL=8/CL=2).
module tb_sdram_dq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // Default instance: DW=16, BL=4, CL=3.
  logic        wr_start0, rd_start0, wr_req0, rd_valid0, rd_last0, busy0, err0;
  logic [15:0] wr_data0, rd_data0, m0_dq;
  logic [1:0]  wr_mask0, dqm0;
  logic        m0_oe;
  wire  [15:0] dq0;
  assign dq0 = m0_oe ? m0_dq : 16'hzzzz;

  sdram_dq_ctrl #(.DW(16), .BL(4), .CL(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_wr_start(wr_start0), .i_wr_data(wr_data0), .i_wr_mask(wr_mask0), .o_wr_req(wr_req0),
    .i_rd_start(rd_start0), .o_rd_data(rd_data0), .o_rd_valid(rd_valid0), .o_rd_last(rd_last0),
    .o_busy(busy0), .o_err(err0), .o_sdram_dqm(dqm0), .io_sdram_dq(dq0)
  );

  // Sweep instance: DW=8, BL=1, CL=2.
  logic        wr_start1, rd_start1, wr_req1, rd_valid1, rd_last1, busy1, err1;
  logic [7:0]  wr_data1, rd_data1, m1_dq;
  logic [0:0]  wr_mask1, dqm1;
  logic        m1_oe;
  wire  [7:0]  dq1;
  assign dq1 = m1_oe ? m1_dq : 8'hzz;

  sdram_dq_ctrl #(.DW(8), .BL(1), .CL(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_wr_start(wr_start1), .i_wr_data(wr_data1), .i_wr_mask(wr_mask1), .o_wr_req(wr_req1),
    .i_rd_start(rd_start1), .o_rd_data(rd_data1), .o_rd_valid(rd_valid1), .o_rd_last(rd_last1),
    .o_busy(busy1), .o_err(err1), .o_sdram_dqm(dqm1), .io_sdram_dq(dq1)
  );

  // Sweep instance: DW=64, BL=8, CL=2.
  logic        wr_start2, rd_start2, wr_req2, rd_valid2, rd_last2, busy2, err2;
  logic [63:0] wr_data2, rd_data2, m2_dq;
  logic [7:0]  wr_mask2, dqm2;
  logic        m2_oe;
  wire  [63:0] dq2;
  assign dq2 = m2_oe ? m2_dq : {64{1'bz}};

  sdram_dq_ctrl #(.DW(64), .BL(8), .CL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_wr_start(wr_start2), .i_wr_data(wr_data2), .i_wr_mask(wr_mask2), .o_wr_req(wr_req2),
    .i_rd_start(rd_start2), .o_rd_data(rd_data2), .o_rd_valid(rd_valid2), .o_rd_last(rd_last2),
    .o_busy(busy2), .o_err(err2), .o_sdram_dqm(dqm2), .io_sdram_dq(dq2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle (output sample point).
  task automatic smp();
    @(negedge clk);
  endtask

  // Read burst on the default instance; the memory model drives word k = base+k in T3..T6.
  // In T0..T2 the model drives zeros, so any DUT drive would show up on the bus.
  task automatic rd0(input logic [15:0] base);
    for (int t = 0; t <= 8; t++) begin
      cyc();
      wr_start0 = 1'b0;
      rd_start0 = (t == 0);
      m0_oe     = (t <= 6);
      m0_dq     = (t >= 3) ? (base + 16'(t - 3)) : 16'h0000;
      smp();
      chk("rd_valid", rd_valid0, (t >= 4 && t <= 7));
      chk("rd_last",  rd_last0,  (t == 7));
      chk("rd_busy",  busy0,     (t >= 1 && t <= 7));
      chk("rd_err",   err0,      1'b0);
      if (t <= 6) chk("rd_bus", dq0, m0_dq);
      if (t >= 4 && t <= 7) chk("rd_data", rd_data0, base + 16'(t - 4));
      if (t == 8) chk("rd_hold", rd_data0, base + 16'd3);
    end
    m0_oe = 1'b0;
  endtask

  function automatic logic [63:0] rw(input int k);
    return 64'h0101_0101_0101_0101 * 64'(k + 1);
  endfunction

  function automatic logic [63:0] ww(input int k);
    return 64'hF0F0_F0F0_0000_0000 | 64'(k + 1);
  endfunction

  logic [15:0] wa [4];
  logic [15:0] wb [4];

  initial begin
    wa = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    wb = '{16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04};
    rst_n = 1'b0;
    wr_start0 = 1'b0; rd_start0 = 1'b0; wr_data0 = 16'h0000; wr_mask0 = 2'b00; m0_oe = 1'b0; m0_dq = 16'h0000;
    wr_start1 = 1'b0; rd_start1 = 1'b0; wr_data1 = 8'h00; wr_mask1 = 1'b0; m1_oe = 1'b0; m1_dq = 8'h00;
    wr_start2 = 1'b0; rd_start2 = 1'b0; wr_data2 = 64'h0; wr_mask2 = 8'h00; m2_oe = 1'b0; m2_dq = 64'h0;

    // Reset state.
    cyc(); cyc();
    m0_oe = 1'b1;
    smp();
    chk("rst_wr_req", wr_req0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_err", err0, 1'b0);
    chk("rst_valid", rd_valid0, 1'b0);
    chk("rst_last", rd_last0, 1'b0);
    chk("rst_rdata", rd_data0, 16'h0000);
    chk("rst_dqm", dqm0, 2'b00);
    chk("rst_bus", dq0, 16'h0000);
    cyc();
    rst_n = 1'b1;
    m0_oe = 1'b0;

    // Write A0..A3, word 2 masked 01, plus a rejected read start in T2.
    for (int t = 0; t <= 5; t++) begin
      cyc();
      wr_start0 = (t == 0);
      rd_start0 = (t == 2);
      wr_data0  = (t <= 3) ? wa[t[1:0]] : 16'hDEAD;
      wr_mask0  = (t == 2) ? 2'b01 : 2'b00;
      m0_oe     = (t == 5);
      m0_dq     = 16'h0000;
      smp();
      chk("w_req", wr_req0, (t <= 3));
      chk("w_busy", busy0, (t >= 1 && t <= 4));
      chk("w_err", err0, (t == 3));
      chk("w_dqm", dqm0, (t == 3) ? 2'b01 : 2'b00);
      chk("w_valid", rd_valid0, 1'b0);
      if (t >= 1 && t <= 4) chk("w_dq", dq0, wa[2'(t - 1)]);
      if (t == 5) chk("w_hiz", dq0, 16'h0000);
    end
    m0_oe = 1'b0;

    // Plain read burst.
    rd0(16'hB000);

    // Both starts in IDLE: write wins, error pulses in T1.
    for (int t = 0; t <= 4; t++) begin
      cyc();
      wr_start0 = (t == 0);
      rd_start0 = (t == 0);
      wr_data0  = (t <= 3) ? wb[t[1:0]] : 16'hDEAD;
      wr_mask0  = 2'b00;
      smp();
      chk("bw_req", wr_req0, (t <= 3));
      chk("bw_err", err0, (t == 1));
      chk("bw_busy", busy0, (t >= 1));
      chk("bw_valid", rd_valid0, 1'b0);
      if (t >= 1) chk("bw_dq", dq0, wb[2'(t - 1)]);
    end

    // Read issued in the very cycle the write returns to IDLE.
    rd0(16'h7100);

    // Reset during T2 of a write.
    for (int t = 0; t <= 2; t++) begin
      cyc();
      wr_start0 = (t == 0);
      rd_start0 = 1'b0;
      wr_data0  = 16'h9999;
      wr_mask0  = 2'b11;
      if (t == 2) begin
        wr_start0 = 1'b0;
        m0_oe = 1'b1;
        m0_dq = 16'h0000;
        rst_n = 1'b0;
        #1;
        chk("ar_bus", dq0, 16'h0000);
        chk("ar_busy", busy0, 1'b0);
        chk("ar_dqm", dqm0, 2'b00);
        chk("ar_req", wr_req0, 1'b0);
        chk("ar_valid", rd_valid0, 1'b0);
        chk("ar_last", rd_last0, 1'b0);
        chk("ar_err", err0, 1'b0);
        chk("ar_rdata", rd_data0, 16'h0000);
      end
    end
    cyc();
    rst_n = 1'b1;
    m0_oe = 1'b0;
    rd0(16'h3C00);

    // DW=8, BL=1, CL=2: read then back-to-back write.
    for (int t = 0; t <= 6; t++) begin
      cyc();
      rd_start1 = (t == 0);
      wr_start1 = (t == 4);
      wr_data1  = (t == 4) ? 8'h5A : 8'hFF;
      wr_mask1  = (t == 4) ? 1'b1 : 1'b0;
      m1_oe     = (t != 5);
      m1_dq     = (t == 2) ? 8'hC3 : 8'h00;
      smp();
      chk("s1_valid", rd_valid1, (t == 3));
      chk("s1_last", rd_last1, (t == 3));
      chk("s1_busy", busy1, ((t >= 1 && t <= 3) || t == 5));
      chk("s1_req", wr_req1, (t == 4));
      chk("s1_err", err1, 1'b0);
      chk("s1_dqm", dqm1, (t == 5));
      chk("s1_bus", dq1, (t == 5) ? 8'h5A : m1_dq);
      if (t >= 3) chk("s1_rdata", rd_data1, 8'hC3);
    end
    m1_oe = 1'b0;

    // DW=64, BL=8, CL=2: read then back-to-back write.
    for (int t = 0; t <= 20; t++) begin
      cyc();
      rd_start2 = (t == 0);
      wr_start2 = (t == 11);
      wr_data2  = (t >= 11 && t <= 18) ? ww(t - 11) : 64'hDEAD_BEEF_DEAD_BEEF;
      wr_mask2  = (t >= 11 && t <= 18) ? 8'(t - 11) : 8'hFF;
      m2_oe     = !(t >= 12 && t <= 19);
      m2_dq     = (t >= 2 && t <= 9) ? rw(t - 2) : 64'h0;
      smp();
      chk("s2_valid", rd_valid2, (t >= 3 && t <= 10));
      chk("s2_last", rd_last2, (t == 10));
      chk("s2_busy", busy2, ((t >= 1 && t <= 10) || (t >= 12 && t <= 19)));
      chk("s2_req", wr_req2, (t >= 11 && t <= 18));
      chk("s2_err", err2, 1'b0);
      chk("s2_dqm", dqm2, (t >= 12 && t <= 19) ? 8'(t - 12) : 8'h00);
      chk("s2_bus", dq2, (t >= 12 && t <= 19) ? ww(t - 12) : m2_dq);
      if (t >= 3) chk("s2_rdata", rd_data2, (t <= 10) ? rw(t - 3) : rw(7));
    end
    m2_oe = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
